// File: rtl/nop_descriptor_merge.sv
// nop_descriptor_merge: merges (tsntag, bufid) descriptors from SRC_NUM sources
// into one output port. Each source has its own small FIFO. A two-state FSM
// pops one descriptor at a time, using strict-priority or round-robin selection,
// and holds it on a valid/ready handshake.
// Optional build macro NOP_DROP_CNT_EN enables saturating per-source drop counters.
module nop_descriptor_merge #(
  parameter int SRC_NUM = 2,
  parameter int TAG_W   = 48,
  parameter int BUFID_W = 9,
  parameter int FIFO_AW = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [SRC_NUM*TAG_W-1:0]   iv_tsntag,
  input  logic [SRC_NUM*BUFID_W-1:0] iv_bufid,
  input  logic [SRC_NUM-1:0]         iv_descriptor_wr,
  output logic [SRC_NUM-1:0]         ov_descriptor_ack,
  input  logic                       i_rr_mode,
  output logic [TAG_W-1:0]           ov_tsntag,
  output logic [BUFID_W-1:0]         ov_bufid,
  output logic [2:0]                 ov_src_id,
  output logic                       o_descriptor_valid,
  input  logic                       i_descriptor_ready,
  output logic                       o_pkt_cnt_pulse,
  output logic                       o_fifo_overflow_pulse,
  output logic [SRC_NUM*16-1:0]      ov_drop_cnt,
  input  logic                       i_cnt_clr
);

  localparam int ENT_W = TAG_W + BUFID_W;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [2:0] RR_INIT = 3'(SRC_NUM - 1);

  typedef enum logic {IDLE_S, WAIT_S} state_t;

  state_t             state, state_next;
  logic [ENT_W-1:0]   head [8];      // head entry of each FIFO, padded to 8 sources
  logic [7:0]         nonempty;      // padded so a 3-bit index is always in range
  logic [SRC_NUM-1:0] full;
  logic [SRC_NUM-1:0] drop;
  logic [SRC_NUM-1:0] pop;
  logic               load;
  logic               found;
  logic [2:0]         grant_idx;
  logic [2:0]         rr_ptr;
  logic [3:0]         cand;

  // A write is dropped when the FIFO was already full before the edge
  assign drop = iv_descriptor_wr & full;
  assign pop  = load ? SRC_NUM'(8'd1 << grant_idx) : '0;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_src
      if (gi < SRC_NUM) begin : g_fifo
        logic [ENT_W-1:0]   mem [DEPTH];
        logic [FIFO_AW-1:0] wr_ptr;
        logic [FIFO_AW-1:0] rd_ptr;
        logic [FIFO_AW:0]   usedw;
        logic               wr_en;

        // usedw never exceeds DEPTH, so its top bit alone means full
        assign full[gi]     = usedw[FIFO_AW];
        assign nonempty[gi] = (usedw != '0);
        assign wr_en        = iv_descriptor_wr[gi] & ~usedw[FIFO_AW];
        assign head[gi]     = mem[rd_ptr];

        // Descriptor storage; contents need no reset
        always_ff @(posedge i_clk) begin
          if (wr_en)
            mem[wr_ptr] <= {iv_tsntag[gi*TAG_W +: TAG_W], iv_bufid[gi*BUFID_W +: BUFID_W]};
        end

        // Pointer and occupancy bookkeeping; push and pop may coincide
        always_ff @(posedge i_clk) begin
          if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
          end else begin
            if (wr_en)   wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop[gi]) rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({wr_en, pop[gi]})
              2'b10:   usedw <= usedw + (FIFO_AW+1)'(1);
              2'b01:   usedw <= usedw - (FIFO_AW+1)'(1);
              default: usedw <= usedw;
            endcase
          end
        end
      end else begin : g_pad
        assign nonempty[gi] = 1'b0;
        assign head[gi]     = '0;
      end
    end
  endgenerate

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE_S;
    else          state <= state_next;
  end

  // Source selection and next-state logic
  always_comb begin
    state_next = state;
    load       = 1'b0;
    grant_idx  = '0;
    found      = 1'b0;
    cand       = '0;
    if (i_rr_mode) begin
      for (int i = 1; i <= SRC_NUM; i++) begin
        cand = {1'b0, rr_ptr} + 4'(i);
        if (cand >= 4'(SRC_NUM)) cand = cand - 4'(SRC_NUM);
        if (!found && nonempty[cand[2:0]]) begin
          found     = 1'b1;
          grant_idx = cand[2:0];
        end
      end
    end else begin
      for (int i = SRC_NUM - 1; i >= 0; i--) begin
        if (nonempty[i]) begin
          found     = 1'b1;
          grant_idx = 3'(i);
        end
      end
    end
    case (state)
      IDLE_S: begin
        if (found) begin
          load       = 1'b1;
          state_next = WAIT_S;
        end
      end
      WAIT_S: begin
        if (o_descriptor_valid && i_descriptor_ready) state_next = IDLE_S;
      end
      default: state_next = IDLE_S;
    endcase
  end

  // Output register, handshake, acks, pulses and round-robin pointer
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ov_tsntag             <= '0;
      ov_bufid              <= '0;
      ov_src_id             <= '0;
      o_descriptor_valid    <= 1'b0;
      o_pkt_cnt_pulse       <= 1'b0;
      o_fifo_overflow_pulse <= 1'b0;
      ov_descriptor_ack     <= '0;
      rr_ptr                <= RR_INIT;
    end else begin
      ov_descriptor_ack     <= iv_descriptor_wr;
      o_fifo_overflow_pulse <= |drop;
      o_pkt_cnt_pulse       <= 1'b0;
      if (load) begin
        {ov_tsntag, ov_bufid} <= head[grant_idx];
        ov_src_id             <= grant_idx;
        o_descriptor_valid    <= 1'b1;
        rr_ptr                <= grant_idx;
      end else if (state == WAIT_S && o_descriptor_valid && i_descriptor_ready) begin
        o_descriptor_valid <= 1'b0;
        o_pkt_cnt_pulse    <= 1'b1;
      end
    end
  end

`ifdef NOP_DROP_CNT_EN
  generate
    for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_cnt
      logic [15:0] cnt;
      // Saturating drop counter; clear has priority over increment
      always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_cnt_clr) cnt <= '0;
        else if (drop[gi] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end
      assign ov_drop_cnt[gi*16 +: 16] = cnt;
    end
  endgenerate
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = i_cnt_clr;
  assign ov_drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_nop_descriptor_merge.sv
// Testbench for nop_descriptor_merge (SRC_NUM=2, FIFO_AW=2). Expected
// descriptors are queued when stimulus is driven and popped as the DUT emits them.
module tb_nop_descriptor_merge;
  localparam int SRC_NUM = 2;
  localparam int TAG_W   = 48;
  localparam int BUFID_W = 9;
  localparam int FIFO_AW = 2;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [SRC_NUM*TAG_W-1:0]   tsntag = '0;
  logic [SRC_NUM*BUFID_W-1:0] bufid_in = '0;
  logic [SRC_NUM-1:0]         wr = '0;
  logic [SRC_NUM-1:0]         ack;
  logic                       rr_mode = 1'b0;
  logic                       ready = 1'b0;
  logic                       cnt_clr = 1'b0;
  logic [TAG_W-1:0]           tag_out;
  logic [BUFID_W-1:0]         bufid_out;
  logic [2:0]                 src_out;
  logic                       valid;
  logic                       pkt_pulse;
  logic                       ovf_pulse;
  logic [SRC_NUM*16-1:0]      drop_cnt;

  typedef struct packed {
    logic [2:0]  src;
    logic [8:0]  bufid;
    logic [47:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  nop_descriptor_merge #(
    .SRC_NUM(SRC_NUM), .TAG_W(TAG_W), .BUFID_W(BUFID_W), .FIFO_AW(FIFO_AW)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .iv_tsntag             (tsntag),
    .iv_bufid              (bufid_in),
    .iv_descriptor_wr      (wr),
    .ov_descriptor_ack     (ack),
    .i_rr_mode             (rr_mode),
    .ov_tsntag             (tag_out),
    .ov_bufid              (bufid_out),
    .ov_src_id             (src_out),
    .o_descriptor_valid    (valid),
    .i_descriptor_ready    (ready),
    .o_pkt_cnt_pulse       (pkt_pulse),
    .o_fifo_overflow_pulse (ovf_pulse),
    .ov_drop_cnt           (drop_cnt),
    .i_cnt_clr             (cnt_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] tag_of(input int src, input logic [8:0] b);
    return {8'hA5, 5'(src), 26'h0, b};
  endfunction

  function automatic exp_t mk(input int src, input logic [8:0] b);
    return '{src: 3'(src), bufid: b, tag: tag_of(src, b)};
  endfunction

  // Drive one write cycle; returns at the negedge right after the sampling edge
  task automatic drive_wr(input logic [1:0] mask, input logic [8:0] b0, input logic [8:0] b1);
    @(negedge clk);
    wr       = mask;
    bufid_in = {b1, b0};
    tsntag   = {tag_of(1, b1), tag_of(0, b0)};
    @(negedge clk);
    wr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Wait (bounded) for a valid descriptor, capture it, let one handshake edge pass
  task automatic get_out(output bit ok, output exp_t got);
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (valid === 1'b1) begin
        ok  = 1'b1;
        got = {src_out, bufid_out, tag_out};
      end else begin
        @(negedge clk);
      end
    end
    if (ok) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({valid, pkt_pulse, ovf_pulse, ack} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got valid=%b pkt=%b ovf=%b ack=%b, expected all 0", valid, pkt_pulse, ovf_pulse, ack);
    end
    n_cmp++;
    if ({tag_out, bufid_out, src_out, drop_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got tag=%h bufid=%h src=%0d drop=%h, expected 0", tag_out, bufid_out, src_out, drop_cnt);
    end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    exp_t e;
    @(negedge clk);
    wr = 2'b01; tsntag = '0; bufid_in = '0;
    tsntag[47:0] = 48'h1; bufid_in[8:0] = 9'h05;
    sb.push_back('{src: 3'd0, bufid: 9'h05, tag: 48'h1});
    @(negedge clk);
    wr = '0;
    n_cmp++;
    if (ack !== 2'b01 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_T+1: got ack=%b valid=%b, expected ack=01 valid=0", ack, valid);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if (valid !== 1'b1 || {src_out, bufid_out, tag_out} !== e || ack !== 2'b00) begin
      n_bad++;
      $display("FAIL basic_T+2: got valid=%b src=%0d bufid=%h tag=%h ack=%b, expected valid=1 src=%0d bufid=%h tag=%h ack=00",
               valid, src_out, bufid_out, tag_out, ack, e.src, e.bufid, e.tag);
    end
    ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pkt_pulse !== 1'b1 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_handoff: got pkt=%b valid=%b, expected pkt=1 valid=0", pkt_pulse, valid);
    end
    @(negedge clk);
    n_cmp++;
    if (pkt_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse_width: got pkt=%b, expected 0", pkt_pulse);
    end
    ready = 1'b0;
    $display("test_basic done");
  endtask

  task automatic test_overflow();
    bit ok; exp_t got, e;
    do_reset();
    rr_mode = 1'b0;
    drive_wr(2'b01, 9'h50, 9'h0);
    sb.push_back(mk(0, 9'h50));
    for (int i = 1; i <= 5; i++) begin
      drive_wr(2'b10, 9'h0, 9'(i));
      if (i < 5) sb.push_back(mk(1, 9'(i)));
      n_cmp++;
      if (ack !== 2'b10 || ovf_pulse !== (i == 5)) begin
        n_bad++;
        $display("FAIL overflow_wr%0d: got ack=%b ovf=%b, expected ack=10 ovf=%b", i, ack, ovf_pulse, (i == 5));
      end
    end
    n_cmp++;
`ifdef NOP_DROP_CNT_EN
    if (drop_cnt !== {16'd1, 16'd0}) begin
`else
    if (drop_cnt !== '0) begin
`endif
      n_bad++;
      $display("FAIL drop_cnt: got %h", drop_cnt);
    end
    ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      get_out(ok, got);
      e = (sb.size() != 0) ? sb.pop_front() : '1;
      n_cmp++;
      if (!ok || got !== e) begin
        n_bad++;
        $display("FAIL overflow_out%0d: got seen=%0d src=%0d bufid=%h, expected src=%0d bufid=%h", n, ok, got.src, got.bufid, e.src, e.bufid);
      end
    end
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    n_cmp++;
    if (drop_cnt !== '0) begin
      n_bad++;
      $display("FAIL cnt_clr: got %h, expected 0", drop_cnt);
    end
    $display("test_overflow done");
  endtask

  task automatic test_order(input logic mode);
    bit ok; exp_t got, e;
    do_reset();
    rr_mode = mode;
    drive_wr(2'b11, 9'h10, 9'h20);
    drive_wr(2'b11, 9'h11, 9'h21);
    if (mode) begin
      sb.push_back(mk(0, 9'h10)); sb.push_back(mk(1, 9'h20));
      sb.push_back(mk(0, 9'h11)); sb.push_back(mk(1, 9'h21));
    end else begin
      sb.push_back(mk(0, 9'h10)); sb.push_back(mk(0, 9'h11));
      sb.push_back(mk(1, 9'h20)); sb.push_back(mk(1, 9'h21));
    end
    ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      get_out(ok, got);
      e = (sb.size() != 0) ? sb.pop_front() : '1;
      n_cmp++;
      if (!ok || got !== e) begin
        n_bad++;
        $display("FAIL order_rr%0d[%0d]: got seen=%0d src=%0d bufid=%h, expected src=%0d bufid=%h", mode, n, ok, got.src, got.bufid, e.src, e.bufid);
      end
    end
    $display("test_order rr_mode=%0d done", mode);
  endtask

  task automatic test_simultaneous(input logic mode);
    bit ok; exp_t got, e;
    do_reset();
    rr_mode = mode;
    ready   = 1'b1;
    drive_wr(2'b11, 9'h0A, 9'h0B);
    n_cmp++;
    if (ack !== 2'b11) begin
      n_bad++;
      $display("FAIL simul_ack_rr%0d: got ack=%b, expected 11", mode, ack);
    end
    sb.push_back(mk(0, 9'h0A));
    sb.push_back(mk(1, 9'h0B));
    for (int n = 0; n < 2; n++) begin
      get_out(ok, got);
      e = (sb.size() != 0) ? sb.pop_front() : '1;
      n_cmp++;
      if (!ok || got !== e) begin
        n_bad++;
        $display("FAIL simul_rr%0d[%0d]: got seen=%0d src=%0d bufid=%h, expected src=%0d bufid=%h", mode, n, ok, got.src, got.bufid, e.src, e.bufid);
      end
    end
    $display("test_simultaneous rr_mode=%0d done", mode);
  endtask

  task automatic test_reset_mid();
    bit ok; exp_t got, e; int extra;
    do_reset();
    rr_mode = 1'b0;
    drive_wr(2'b11, 9'h60, 9'h61);
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_pre: got valid=%b, expected 1", valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({valid, pkt_pulse, ovf_pulse, ack, src_out, bufid_out, tag_out} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got valid=%b src=%0d bufid=%h tag=%h ack=%b, expected all 0", valid, src_out, bufid_out, tag_out, ack);
    end
    rst_n = 1'b1;
    sb.delete();
    ready = 1'b1;
    drive_wr(2'b10, 9'h0, 9'h77);
    sb.push_back(mk(1, 9'h77));
    get_out(ok, got);
    e = (sb.size() != 0) ? sb.pop_front() : '1;
    n_cmp++;
    if (!ok || got !== e) begin
      n_bad++;
      $display("FAIL midreset_single: got seen=%0d src=%0d bufid=%h, expected src=%0d bufid=%h", ok, got.src, got.bufid, e.src, e.bufid);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid === 1'b1) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_bad++;
      $display("FAIL midreset_extra: got %0d extra valid cycles, expected 0", extra);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_order(1'b0);
    test_order(1'b1);
    test_simultaneous(1'b0);
    test_simultaneous(1'b1);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
